// File: rtl/hls_call_ctrl.sv
// rtl/hls_call_ctrl.sv - call/return sequencer wrapping a generated compute kernel
// Accepts an argument pair, pulses kernel reset, runs with a watchdog, and returns the result.
module hls_call_ctrl #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout,
  output logic [DATA_W-1:0] kernel_a,
  output logic [DATA_W-1:0] kernel_b,
  output logic              kernel_rst_n,
  input  logic [DATA_W-1:0] kernel_ret,
  input  logic              kernel_done,
  output logic              busy
);

  localparam logic [31:0] LP_RST_LAST = 32'(RST_CYCLES - 1);
  localparam logic [31:0] LP_TO_LAST  = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_RESP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_cnt;
  logic [31:0]       w_cnt_nxt;
  logic [DATA_W-1:0] r_kernel_a;
  logic [DATA_W-1:0] r_kernel_b;
  logic [DATA_W-1:0] w_kernel_a_nxt;
  logic [DATA_W-1:0] w_kernel_b_nxt;
  logic [DATA_W-1:0] r_rsp_data;
  logic [DATA_W-1:0] w_rsp_data_nxt;
  logic              r_rsp_timeout;
  logic              w_rsp_timeout_nxt;
  logic              r_kernel_rst_n;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_kernel_a     <= '0;
      r_kernel_b     <= '0;
      r_rsp_data     <= '0;
      r_rsp_timeout  <= 1'b0;
      r_kernel_rst_n <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_kernel_a     <= w_kernel_a_nxt;
      r_kernel_b     <= w_kernel_b_nxt;
      r_rsp_data     <= w_rsp_data_nxt;
      r_rsp_timeout  <= w_rsp_timeout_nxt;
      // Released only for the cycles the FSM actually spends in RUN.
      r_kernel_rst_n <= (w_state_nxt == ST_RUN);
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_kernel_a_nxt    = r_kernel_a;
    w_kernel_b_nxt    = r_kernel_b;
    w_rsp_data_nxt    = r_rsp_data;
    w_rsp_timeout_nxt = r_rsp_timeout;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_state_nxt    = ST_LAUNCH;
          w_cnt_nxt      = '0;
          w_kernel_a_nxt = req_a;
          w_kernel_b_nxt = req_b;
        end
      end
      ST_LAUNCH: begin
        if (r_cnt == LP_RST_LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      ST_RUN: begin
        w_cnt_nxt = r_cnt + 32'd1;
        // A kernel finishing on the watchdog's last cycle still counts as success.
        if (kernel_done) begin
          w_state_nxt       = ST_RESP;
          w_rsp_data_nxt    = kernel_ret;
          w_rsp_timeout_nxt = 1'b0;
        end else if (r_cnt == LP_TO_LAST) begin
          w_state_nxt       = ST_RESP;
          w_rsp_data_nxt    = '0;
          w_rsp_timeout_nxt = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign req_ready    = (r_state == ST_IDLE);
  assign rsp_valid    = (r_state == ST_RESP);
  assign busy         = (r_state != ST_IDLE);
  assign rsp_data     = r_rsp_data;
  assign rsp_timeout  = r_rsp_timeout;
  assign kernel_a     = r_kernel_a;
  assign kernel_b     = r_kernel_b;
  assign kernel_rst_n = r_kernel_rst_n;

endmodule

// File: tb/tb_hls_call_ctrl.sv
// tb/tb_hls_call_ctrl.sv - directed and randomized checks of hls_call_ctrl against a call-level model
module tb_hls_call_ctrl;

  localparam int DW = 32;
  localparam int R0 = 2;
  localparam int T0 = 1024;
  localparam int R1 = 3;
  localparam int T1 = 16;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_timeout;
  logic [1:0]    kernel_rst_n;
  logic [1:0]    kernel_done;
  logic [1:0]    busy;
  logic          rsp_ready;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic [DW-1:0] rsp_data   [2];
  logic [DW-1:0] kernel_a   [2];
  logic [DW-1:0] kernel_b   [2];
  logic [DW-1:0] kernel_ret [2];

  int            total = 0;
  int            bad = 0;
  int            k_cnt [2];
  int            k_lat;
  logic          k_force;
  logic [DW-1:0] k_force_val;

  always #5 sys_clk = ~sys_clk;

  hls_call_ctrl #(.DATA_W(DW), .RST_CYCLES(R0), .TIMEOUT(T0)) u_dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_data(rsp_data[0]),
    .rsp_timeout(rsp_timeout[0]), .kernel_a(kernel_a[0]), .kernel_b(kernel_b[0]),
    .kernel_rst_n(kernel_rst_n[0]), .kernel_ret(kernel_ret[0]),
    .kernel_done(kernel_done[0]), .busy(busy[0])
  );

  hls_call_ctrl #(.DATA_W(DW), .RST_CYCLES(R1), .TIMEOUT(T1)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_data(rsp_data[1]),
    .rsp_timeout(rsp_timeout[1]), .kernel_a(kernel_a[1]), .kernel_b(kernel_b[1]),
    .kernel_rst_n(kernel_rst_n[1]), .kernel_ret(kernel_ret[1]),
    .kernel_done(kernel_done[1]), .busy(busy[1])
  );

  function automatic logic [DW-1:0] gcd(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [DW-1:0] t;
    x = a;
    y = b;
    while (y != 0) begin
      t = y;
      y = x % y;
      x = t;
    end
    return x;
  endfunction

  // Kernel stand-in: after k_lat released cycles it sits in its return state with the gcd.
  always @(negedge sys_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (kernel_rst_n[i] !== 1'b1) begin
        k_cnt[i]       = 0;
        kernel_done[i] = 1'b0;
        kernel_ret[i]  = $urandom;
      end else begin
        k_cnt[i]       = k_cnt[i] + 1;
        kernel_done[i] = (k_lat != 0) && (k_cnt[i] >= k_lat);
        kernel_ret[i]  = kernel_done[i] ? (k_force ? k_force_val : gcd(kernel_a[i], kernel_b[i]))
                                        : $urandom;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input int s);
    chk("rst_req_ready", 64'(req_ready[s]), 64'(1));
    chk("rst_rsp_valid", 64'(rsp_valid[s]), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data[s]), 64'(0));
    chk("rst_rsp_timeout", 64'(rsp_timeout[s]), 64'(0));
    chk("rst_kernel_a", 64'(kernel_a[s]), 64'(0));
    chk("rst_kernel_b", 64'(kernel_b[s]), 64'(0));
    chk("rst_kernel_rst_n", 64'(kernel_rst_n[s]), 64'(0));
    chk("rst_busy", 64'(busy[s]), 64'(0));
  endtask

  // One full call: the model predicts which edge the response appears on and what it carries.
  task automatic do_call(input int s, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input int lat, input logic frc, input logic [DW-1:0] fval,
                         input int hold, input logic keep_valid);
    int            rc;
    int            tmo;
    int            resp_n;
    logic          to;
    logic [DW-1:0] exp_d;
    rc     = (s != 0) ? R1 : R0;
    tmo    = (s != 0) ? T1 : T0;
    to     = (lat == 0) || (lat > tmo);
    resp_n = rc + (to ? tmo : lat);
    exp_d  = to ? '0 : (frc ? fval : gcd(a, b));
    k_lat       = lat;
    k_force     = frc;
    k_force_val = fval;
    req_a        = a;
    req_b        = b;
    req_valid[s] = 1'b1;
    chk("req_ready_idle", 64'(req_ready[s]), 64'(1));
    @(posedge sys_clk);
    #1;
    if (!keep_valid) req_valid[s] = 1'b0;
    chk("kernel_a", 64'(kernel_a[s]), 64'(a));
    chk("kernel_b", 64'(kernel_b[s]), 64'(b));
    chk("busy_accept", 64'(busy[s]), 64'(1));
    chk("req_ready_busy", 64'(req_ready[s]), 64'(0));
    chk("krst_accept", 64'(kernel_rst_n[s]), 64'(0));
    for (int n = 1; n <= resp_n; n++) begin
      @(posedge sys_clk);
      #1;
      chk("kernel_rst_n", 64'(kernel_rst_n[s]), 64'((n >= rc) && (n < resp_n)));
      chk("rsp_valid_edge", 64'(rsp_valid[s]), 64'(n == resp_n));
    end
    chk("rsp_data", 64'(rsp_data[s]), 64'(exp_d));
    chk("rsp_timeout", 64'(rsp_timeout[s]), 64'(to));
    for (int h = 0; h < hold; h++) begin
      @(posedge sys_clk);
      #1;
      chk("hold_rsp_valid", 64'(rsp_valid[s]), 64'(1));
      chk("hold_rsp_data", 64'(rsp_data[s]), 64'(exp_d));
      chk("hold_rsp_timeout", 64'(rsp_timeout[s]), 64'(to));
      chk("hold_req_ready", 64'(req_ready[s]), 64'(0));
      chk("hold_krst", 64'(kernel_rst_n[s]), 64'(0));
    end
    rsp_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    rsp_ready = 1'b0;
    chk("hs_rsp_valid", 64'(rsp_valid[s]), 64'(0));
    chk("hs_req_ready", 64'(req_ready[s]), 64'(1));
    chk("hs_busy", 64'(busy[s]), 64'(0));
    chk("hs_kernel_a_kept", 64'(kernel_a[s]), 64'(a));
  endtask

  initial begin
    int            s;
    int            lat;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] m;
    sys_rst_n   = 1'b0;
    req_valid   = '0;
    req_a       = '0;
    req_b       = '0;
    rsp_ready   = 1'b0;
    k_lat       = 0;
    k_force     = 1'b0;
    k_force_val = '0;
    #12;
    chk_reset(0);
    chk_reset(1);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;

    // Plain gcd call, then the same call with a stalled response channel.
    do_call(0, 48, 18, 20, 1'b0, '0, 0, 1'b0);
    do_call(0, 48, 18, 20, 1'b0, '0, 10, 1'b0);

    // Watchdog: never done, done on the last cycle, one cycle late, one cycle early.
    do_call(1, 100, 75, 0, 1'b0, '0, 0, 1'b0);
    do_call(1, 5, 3, 16, 1'b1, 32'd7, 2, 1'b0);
    do_call(1, 40, 24, 17, 1'b0, '0, 0, 1'b0);
    do_call(1, 40, 24, 15, 1'b0, '0, 1, 1'b0);

    // Asynchronous reset in the middle of RUN drops the call.
    k_lat        = 20;
    k_force      = 1'b0;
    req_a        = 77;
    req_b        = 33;
    req_valid[0] = 1'b1;
    @(posedge sys_clk);
    #1;
    req_valid[0] = 1'b0;
    for (int n = 0; n < R0 + 5; n++) begin
      @(posedge sys_clk);
      #1;
    end
    chk("pre_rst_krst", 64'(kernel_rst_n[0]), 64'(1));
    sys_rst_n = 1'b0;
    #1;
    chk_reset(0);
    #1;
    sys_rst_n = 1'b1;
    do_call(0, 9, 6, 20, 1'b0, '0, 0, 1'b0);

    // Back-to-back with req_valid held high throughout.
    do_call(0, 12, 8, 6, 1'b0, '0, 0, 1'b1);
    do_call(0, 35, 14, 6, 1'b0, '0, 0, 1'b1);
    req_valid[0] = 1'b0;

    for (int it = 0; it < 12; it++) begin
      s   = int'($urandom_range(0, 1));
      m   = DW'($urandom_range(1, 12));
      a   = m * DW'($urandom_range(1, 3000));
      b   = m * DW'($urandom_range(1, 3000));
      lat = (s != 0) ? int'($urandom_range(0, 22)) : int'($urandom_range(1, 40));
      do_call(s, a, b, lat, 1'b0, '0, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
